timer_counter: RTL and testbench

Counting core of the timer IP. Sits directly downstream of the register block (TDR/TCR/TSR). It takes the decoded TCR fields and the TDR value, divides `pclk` into a count tick, and runs the count register up or down. It sets the sticky overflow/underflow flags that the register block returns as TSR bits 0/1.

---
 rtl/timer_pkg.sv | 30 +++
 rtl/timer_prescaler.sv | 50 +++++
 rtl/timer_counter.sv | 76 +++++++
 tb/tb_timer_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer IP: TCR/TSR bit positions, prescaler
// select encodings and the divide-value lookup.
package timer_pkg;

  localparam int unsigned TCR_LOAD_BIT   = 7;
  localparam int unsigned TCR_DW_BIT     = 5;
  localparam int unsigned TCR_EN_BIT     = 4;
  localparam int unsigned TCR_CLK_SEL_HI = 1;
  localparam int unsigned TCR_CLK_SEL_LO = 0;

  localparam int unsigned TSR_OVF_BIT = 0;
  localparam int unsigned TSR_UDF_BIT = 1;

  typedef enum logic [1:0] {
    SEL_DIV2  = 2'b00,
    SEL_DIV4  = 2'b01,
    SEL_DIV8  = 2'b10,
    SEL_DIV16 = 2'b11
  } clk_sel_e;

  function automatic int unsigned div_n(input clk_sel_e sel);
    case (sel)
      SEL_DIV2:  div_n = 2;
      SEL_DIV4:  div_n = 4;
      SEL_DIV8:  div_n = 8;
      default:   div_n = 16;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides pclk into a one-cycle registered tick every N cycles while enabled;
// a change of clk_sel restarts the division period.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] clk_sel,
  output logic       tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       clk_sel_q, clk_sel_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] div_last;

  assign div_last = DIV_W'(div_n(clk_sel_e'(clk_sel)) - 1);

  always_comb begin
    div_cnt_d = '0;
    tick_d    = 1'b0;
    clk_sel_d = clk_sel;
    if (en && !load && (clk_sel == clk_sel_q)) begin
      if (div_cnt_q == div_last) begin
        tick_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      div_cnt_q <= '0;
      clk_sel_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_sel_q <= clk_sel_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/timer_counter.sv
// Timer counting core: loadable up/down counter advanced by the prescaler
// tick, with sticky overflow/underflow flags for TSR[1:0].
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [CNT_W-1:0] tdr,
  input  logic             load,
  input  logic             dw,
  input  logic             en,
  input  logic [1:0]       clk_sel,
  input  logic             ovf_clr,
  input  logic             udf_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             ovf,
  output logic             udf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             set_ovf, set_udf;

  timer_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .pclk    (pclk),
    .preset  (preset),
    .en      (en),
    .load    (load),
    .clk_sel (clk_sel),
    .tick    (tick)
  );

  always_comb begin
    cnt_d   = cnt_q;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (load) begin
      cnt_d = tdr;
    end else if (en && tick) begin
      if (dw) begin
        cnt_d   = cnt_q - CNT_W'(1);
        set_udf = (cnt_q == '0);
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        set_ovf = (cnt_q == '1);
      end
    end
    // a set in the same cycle as a clear wins
    ovf_d = set_ovf ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    udf_d = set_udf ? 1'b1 : (udf_clr ? 1'b0 : udf_q);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboarded bench for timer_counter: a cycle-level reference model pushes
// expected outputs each edge; a negedge monitor pops and compares.
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       preset;
  logic [7:0] tdr;
  logic       load, dw, en, ovf_clr, udf_clr;
  logic [1:0] clk_sel;
  logic [7:0] cnt;
  logic       tick, ovf, udf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cnt;
    bit tick;
    bit ovf;
    bit udf;
  } exp_t;

  exp_t exp_q[$];

  timer_counter #(
    .CNT_W (8),
    .DIV_W (4)
  ) dut (
    .pclk    (clk),
    .preset  (preset),
    .tdr     (tdr),
    .load    (load),
    .dw      (dw),
    .en      (en),
    .clk_sel (clk_sel),
    .ovf_clr (ovf_clr),
    .udf_clr (udf_clr),
    .cnt     (cnt),
    .tick    (tick),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 clk = ~clk;

  // Reference model: a run of consecutive eligible cycles yields a tick
  // whenever the run length is a multiple of N.
  int m_cnt = 0;
  bit m_tick = 0, m_ovf = 0, m_udf = 0;
  int run_len = 0;
  int prev_sel = 0;
  int n_div;
  bit eligible, set_o, set_u;

  always @(posedge clk) begin
    if (preset) begin
      m_cnt = 0; m_tick = 0; m_ovf = 0; m_udf = 0;
      run_len = 0; prev_sel = 0;
    end else begin
      set_o = 0;
      set_u = 0;
      if (load) begin
        m_cnt = int'(tdr);
      end else if (en && m_tick) begin
        if (dw) begin
          if (m_cnt == 0) begin m_cnt = 255; set_u = 1; end
          else m_cnt = m_cnt - 1;
        end else begin
          if (m_cnt == 255) begin m_cnt = 0; set_o = 1; end
          else m_cnt = m_cnt + 1;
        end
      end
      if (set_o) m_ovf = 1; else if (ovf_clr) m_ovf = 0;
      if (set_u) m_udf = 1; else if (udf_clr) m_udf = 0;
      n_div = 2 ** (int'(clk_sel) + 1);
      eligible = en && !load && (int'(clk_sel) == prev_sel);
      run_len = eligible ? run_len + 1 : 0;
      m_tick = eligible && (run_len % n_div == 0);
      prev_sel = int'(clk_sel);
    end
    exp_q.push_back('{cnt: m_cnt, tick: m_tick, ovf: m_ovf, udf: m_udf});
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_cnt",  int'(cnt),  e.cnt);
      chk("sb_tick", int'(tick), int'(e.tick));
      chk("sb_ovf",  int'(ovf),  int'(e.ovf));
      chk("sb_udf",  int'(udf),  int'(e.udf));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    preset = 1; tdr = '0; load = 0; dw = 0; en = 0;
    clk_sel = 2'b00; ovf_clr = 0; udf_clr = 0;
    #1;
    step(2);
    preset = 0;
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_flags", int'({tick, ovf, udf}), 0);

    // underflow at divide-by-4 from 0xFF
    tdr = 8'hFF; load = 1; dw = 1; clk_sel = 2'b01;
    step();
    load = 0; en = 1;
    step(881);
    chk("udf_220_ticks_cnt", int'(cnt), 'h23);
    chk("udf_220_ticks_udf", int'(udf), 0);
    step(143);
    chk("udf_pre_wrap_cnt", int'(cnt), 'h00);
    chk("udf_pre_wrap_udf", int'(udf), 0);
    step();
    chk("udf_wrap_cnt", int'(cnt), 'hFF);
    chk("udf_wrap_udf", int'(udf), 1);

    // overflow at divide-by-2 from 0xFE, clearing udf during the load
    en = 0; tdr = 8'hFE; load = 1; dw = 0; clk_sel = 2'b00; udf_clr = 1;
    step();
    udf_clr = 0;
    chk("udf_clear", int'(udf), 0);
    load = 0; en = 1;
    step(4);
    chk("ovf_pre_cnt", int'(cnt), 'hFF);
    chk("ovf_pre_ovf", int'(ovf), 0);
    step();
    chk("ovf_wrap_cnt", int'(cnt), 'h00);
    chk("ovf_wrap_ovf", int'(ovf), 1);
    chk("ovf_wrap_udf", int'(udf), 0);

    // clear coincident with a wrap: set wins
    en = 0; tdr = 8'h00; load = 1; dw = 1;
    step();
    load = 0; en = 1;
    step(2);
    udf_clr = 1;
    step();
    udf_clr = 0;
    chk("set_beats_clr_udf", int'(udf), 1);
    chk("set_beats_clr_cnt", int'(cnt), 'hFF);

    // load held with enable: no ticks, cnt follows tdr
    tdr = 8'h5A; load = 1; en = 1;
    step(10);
    chk("load_hold_cnt", int'(cnt), 'h5A);
    chk("load_hold_tick", int'(tick), 0);
    load = 0; en = 0;
    step(5);
    chk("en_off_cnt", int'(cnt), 'h5A);
    chk("en_off_tick", int'(tick), 0);

    // prescaler select sweep, then randomized traffic
    for (int s = 0; s < 4; s++) begin
      clk_sel = 2'(s); en = 1;
      step(40);
    end
    for (int i = 0; i < 5000; i++) begin
      en      = ($urandom_range(0, 19) != 0);
      load    = ($urandom_range(0, 39) == 0);
      tdr     = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) tdr = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 49) == 0) dw = ~dw;
      if ($urandom_range(0, 99) == 0) clk_sel = 2'($urandom_range(0, 3));
      ovf_clr = ($urandom_range(0, 15) == 0);
      udf_clr = ($urandom_range(0, 15) == 0);
      preset  = ($urandom_range(0, 499) == 0);
      step();
    end
    preset = 0; load = 0; en = 0; ovf_clr = 0; udf_clr = 0;
    step(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
